button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 119 +++++++++++
 tb/tb_button_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-channel push/pop button debouncer with one-cycle FIFO request pulses
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_btn,
    input  logic pop_btn,
    output logic push_pulse,
    output logic pop_pulse,
    output logic push_held,
    output logic pop_held
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    typedef struct packed {
        state_t          st;
        logic [CW-1:0]   cnt;
        logic            ev;
    } step_t;

    // Next-state decode shared by both channels; the counter is zero after any transition.
    function automatic step_t fsm_step(input state_t st, input logic [CW-1:0] cnt, input logic s);
        step_t r;
        r.st  = st;
        r.cnt = '0;
        r.ev  = 1'b0;
        case (st)
            RELEASED: begin
                if (s) r.st = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!s) begin
                    r.st = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    r.st = HELD;
                    r.ev = 1'b1;
                end else begin
                    r.cnt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) r.st = RELEASE_CHK;
            end
            default: begin
                if (s) begin
                    r.st = HELD;
                end else if (cnt == CNT_LAST) begin
                    r.st = RELEASED;
                end else begin
                    r.cnt = cnt + 1'b1;
                end
            end
        endcase
        return r;
    endfunction

    logic [1:0]    r_push_sync;
    logic [1:0]    r_pop_sync;
    state_t        r_push_state;
    state_t        r_pop_state;
    logic [CW-1:0] r_push_cnt;
    logic [CW-1:0] r_pop_cnt;
    logic          r_pop_pending;
    logic          r_push_pulse;
    logic          r_pop_pulse;
    logic          r_push_held;
    logic          r_pop_held;

    step_t w_push_step;
    step_t w_pop_step;

    assign w_push_step = fsm_step(r_push_state, r_push_cnt, ~r_push_sync[1]);
    assign w_pop_step  = fsm_step(r_pop_state,  r_pop_cnt,  ~r_pop_sync[1]);

    // Push wins a same-edge collision; the pop is deferred one cycle via r_pop_pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_push_sync   <= 2'b11;
            r_pop_sync    <= 2'b11;
            r_push_state  <= RELEASED;
            r_pop_state   <= RELEASED;
            r_push_cnt    <= '0;
            r_pop_cnt     <= '0;
            r_pop_pending <= 1'b0;
            r_push_pulse  <= 1'b0;
            r_pop_pulse   <= 1'b0;
            r_push_held   <= 1'b0;
            r_pop_held    <= 1'b0;
        end else begin
            r_push_sync   <= {r_push_sync[0], push_btn};
            r_pop_sync    <= {r_pop_sync[0], pop_btn};
            r_push_state  <= w_push_step.st;
            r_pop_state   <= w_pop_step.st;
            r_push_cnt    <= w_push_step.cnt;
            r_pop_cnt     <= w_pop_step.cnt;
            r_push_pulse  <= w_push_step.ev;
            r_pop_pulse   <= r_pop_pending | (w_pop_step.ev & ~w_push_step.ev);
            r_pop_pending <= w_pop_step.ev & w_push_step.ev;
            r_push_held   <= (w_push_step.st == HELD) || (w_push_step.st == RELEASE_CHK);
            r_pop_held    <= (w_pop_step.st == HELD) || (w_pop_step.st == RELEASE_CHK);
        end
    end

    assign push_pulse = r_push_pulse;
    assign pop_pulse  = r_pop_pulse;
    assign push_held  = r_push_held;
    assign pop_held   = r_pop_held;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner against a run-length debounce model
module tb_button_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    logic push_btn;
    logic pop_btn;
    logic push_pulse;
    logic pop_pulse;
    logic push_held;
    logic pop_held;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_btn   (push_btn),
        .pop_btn    (pop_btn),
        .push_pulse (push_pulse),
        .pop_pulse  (pop_pulse),
        .push_held  (push_held),
        .pop_held   (pop_held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_push_seen = 0;
    int n_pop_seen  = 0;
    int last_push_cyc = -100;
    int last_pop_cyc  = -100;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: raw levels delayed two samples, then a level is accepted
    // once the opposite value has been seen D+1 samples in a row.
    logic [3:0] exp_q[$];
    logic [1:0] raw_hist[$];
    bit   [1:0] acc;
    int         run[2];
    int         owed;

    always @(posedge clk or posedge reset) begin
        logic [1:0] s;
        bit   [1:0] ev;
        bit         pp, qp;
        if (reset) begin
            raw_hist = '{2'b11, 2'b11};
            acc      = 2'b00;
            run[0]   = 0;
            run[1]   = 0;
            owed     = 0;
            exp_q.delete();
            exp_q.push_back(4'b0000);
        end else begin
            s = ~raw_hist.pop_front();
            raw_hist.push_back({pop_btn, push_btn});
            for (int ch = 0; ch < 2; ch++) begin
                ev[ch] = 1'b0;
                if (s[ch] != acc[ch]) begin
                    run[ch]++;
                    if (run[ch] == D + 1) begin
                        acc[ch] = s[ch];
                        run[ch] = 0;
                        ev[ch]  = s[ch];
                    end
                end else begin
                    run[ch] = 0;
                end
            end
            owed += ev[1];
            pp = ev[0];
            qp = 1'b0;
            if (!ev[0] && owed > 0) begin
                qp = 1'b1;
                owed--;
            end
            exp_q.push_back({pp, qp, acc[0], acc[1]});
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        cyc++;
        if (push_pulse) begin n_push_seen++; last_push_cyc = cyc; end
        if (pop_pulse)  begin n_pop_seen++;  last_pop_cyc  = cyc; end
        if (exp_q.size() == 0) begin
            check($sformatf("scoreboard empty at cycle %0d", cyc), 0, 1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("outputs {push_pulse,pop_pulse,push_held,pop_held} cycle %0d", cyc),
                  int'({push_pulse, pop_pulse, push_held, pop_held}), int'(e));
        end
    end

    task automatic drive(input logic p, input logic q, input int n);
        push_btn = p;
        pop_btn  = q;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int b_push, b_pop, t_drive;

    initial begin
        reset    = 1'b1;
        push_btn = 1'b0;
        pop_btn  = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        check("held during reset", int'({push_held, pop_held, push_pulse, pop_pulse}), 0);
        b_push = n_push_seen; b_pop = n_pop_seen;
        reset = 1'b0;
        t_drive = cyc;
        drive(0, 0, 20);
        check("reset release push count", n_push_seen - b_push, 1);
        check("reset release pop count", n_pop_seen - b_pop, 1);
        check("reset release pop follows push", last_pop_cyc, last_push_cyc + 1);
        check("reset release push latency", last_push_cyc, t_drive + D + 4);
        drive(1, 1, 12);

        b_push = n_push_seen;
        t_drive = cyc;
        drive(0, 1, 20);
        check("clean press push count", n_push_seen - b_push, 1);
        check("clean press latency", last_push_cyc, t_drive + D + 4);
        drive(1, 1, 12);

        b_push = n_push_seen;
        drive(0, 1, 3);  drive(1, 1, 12);
        drive(0, 1, D);  drive(1, 1, 12);
        check("short glitches push count", n_push_seen - b_push, 0);
        drive(0, 1, D + 1); drive(1, 1, 12);
        check("minimum press push count", n_push_seen - b_push, 1);

        b_push = n_push_seen;
        drive(0, 1, 20); drive(1, 1, 2); drive(0, 1, 20); drive(1, 1, 12);
        check("bounce push count", n_push_seen - b_push, 1);

        b_push = n_push_seen; b_pop = n_pop_seen;
        t_drive = cyc;
        drive(0, 0, 20);
        check("simultaneous push count", n_push_seen - b_push, 1);
        check("simultaneous pop count", n_pop_seen - b_pop, 1);
        check("simultaneous push cycle", last_push_cyc, t_drive + D + 4);
        check("simultaneous pop cycle", last_pop_cyc, t_drive + D + 5);
        drive(1, 1, 12);

        b_push = n_push_seen;
        drive(0, 1, 3);
        reset = 1'b1;
        drive(0, 1, 1);
        reset = 1'b0;
        t_drive = cyc;
        drive(0, 1, 20);
        check("reset mid-press push count", n_push_seen - b_push, 1);
        check("reset mid-press latency", last_push_cyc, t_drive + D + 4);
        drive(1, 1, 12);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                drive(push_btn, pop_btn, int'($urandom_range(1, 2)));
                reset = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
        end
        drive(1, 1, 12);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
